// File: rtl/qpu_exu_wbck_router_if.sv
// qpu_exu_wbck_router_if: result-in, commit-out and per-channel write-back buses of the router.
// slave is the router's view; master is the ALU group plus commit/write-back consumers.
interface qpu_exu_wbck_router_if #(
    parameter int XLEN    = 32,
    parameter int NCH     = 4,
    parameter int RFIDX_W = 6,
    parameter int PC_W    = 32
);
    logic                    i_valid;
    logic                    i_ready;
    logic [XLEN-1:0]         i_data;
    logic [RFIDX_W-1:0]      i_rdidx;
    logic [NCH-1:0]          i_chsel;
    logic [PC_W-1:0]         i_pc;
    logic                    i_bjp;
    logic                    i_bjp_prdt;
    logic                    i_bjp_rslv;
    logic                    cmt_o_valid;
    logic                    cmt_o_ready;
    logic [PC_W-1:0]         cmt_o_pc;
    logic                    cmt_o_bjp;
    logic                    cmt_o_bjp_prdt;
    logic                    cmt_o_bjp_rslv;
    logic [NCH-1:0]          wbck_o_valid;
    logic [NCH-1:0]          wbck_o_ready;
    logic [NCH*XLEN-1:0]     wbck_o_data;
    logic [NCH*RFIDX_W-1:0]  wbck_o_rdidx;

    modport slave (
        input  i_valid, i_data, i_rdidx, i_chsel, i_pc, i_bjp, i_bjp_prdt, i_bjp_rslv,
        output i_ready,
        output cmt_o_valid, cmt_o_pc, cmt_o_bjp, cmt_o_bjp_prdt, cmt_o_bjp_rslv,
        input  cmt_o_ready,
        output wbck_o_valid, wbck_o_data, wbck_o_rdidx,
        input  wbck_o_ready
    );

    modport master (
        output i_valid, i_data, i_rdidx, i_chsel, i_pc, i_bjp, i_bjp_prdt, i_bjp_rslv,
        input  i_ready,
        input  cmt_o_valid, cmt_o_pc, cmt_o_bjp, cmt_o_bjp_prdt, cmt_o_bjp_rslv,
        output cmt_o_ready,
        input  wbck_o_valid, wbck_o_data, wbck_o_rdidx,
        output wbck_o_ready
    );
endinterface

// File: rtl/qpu_exu_wbck_router.sv
// qpu_exu_wbck_router: one registered commit slot plus NCH independent write-back FIFOs.
// Define QPU_WBCK_BYPASS_EN to forward a result straight onto an empty, ready channel.
module qpu_exu_wbck_router #(
    parameter int XLEN    = 32,
    parameter int NCH     = 4,
    parameter int DEPTH   = 2,
    parameter int RFIDX_W = 6,
    parameter int PC_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    qpu_exu_wbck_router_if.slave    bus,
    output logic                    o_err
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic            onehot, multi, slot_free, acc;
    logic [NCH-1:0]  can_acc, hit, byp, fifo_vld;
    logic            cmt_vld_q, bjp_q, prdt_q, rslv_q, err_q;
    logic [PC_W-1:0] pc_q;

    assign onehot    = (bus.i_chsel != '0) && ((bus.i_chsel & (bus.i_chsel - 1'b1)) == '0);
    assign multi     = (bus.i_chsel != '0) && !onehot;
    assign slot_free = !cmt_vld_q || bus.cmt_o_ready;
    // i_ready never looks at i_valid; only the target channel's room matters
    assign bus.i_ready = slot_free && (!onehot || |(bus.i_chsel & can_acc));
    assign acc       = bus.i_valid && bus.i_ready;
    assign hit       = {NCH{acc && onehot}} & bus.i_chsel;

`ifdef QPU_WBCK_BYPASS_EN
    assign byp = hit & ~fifo_vld & bus.wbck_o_ready;
`else
    assign byp = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmt_vld_q <= 1'b0;
            pc_q      <= '0;
            bjp_q     <= 1'b0;
            prdt_q    <= 1'b0;
            rslv_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (acc) begin
                cmt_vld_q <= 1'b1;
                pc_q      <= bus.i_pc;
                bjp_q     <= bus.i_bjp;
                prdt_q    <= bus.i_bjp & bus.i_bjp_prdt;
                rslv_q    <= bus.i_bjp & bus.i_bjp_rslv;
            end else if (bus.cmt_o_ready) begin
                cmt_vld_q <= 1'b0;
            end
            if (acc && multi) err_q <= 1'b1;
        end
    end

    assign bus.cmt_o_valid    = cmt_vld_q;
    assign bus.cmt_o_pc       = cmt_vld_q ? pc_q : '0;
    assign bus.cmt_o_bjp      = cmt_vld_q & bjp_q;
    assign bus.cmt_o_bjp_prdt = cmt_vld_q & prdt_q;
    assign bus.cmt_o_bjp_rslv = cmt_vld_q & rslv_q;
    assign o_err              = err_q;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [XLEN-1:0]    dat_q [DEPTH];
        logic [RFIDX_W-1:0] idx_q [DEPTH];
        logic [PW-1:0]      wp_q, rp_q;
        logic [CW-1:0]      cnt_q, cnt_d;
        logic               push, pop;

        assign fifo_vld[k] = cnt_q != '0;
        assign pop         = fifo_vld[k] && bus.wbck_o_ready[k];
        assign push        = hit[k] && !byp[k];
        assign can_acc[k]  = cnt_q != FULL || pop;
        assign cnt_d       = cnt_q + CW'(push) - CW'(pop);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wp_q  <= '0;
                rp_q  <= '0;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
                if (push) wp_q <= wp_q == LAST ? '0 : wp_q + 1'b1;
                if (pop)  rp_q <= rp_q == LAST ? '0 : rp_q + 1'b1;
            end
        end

        // payload storage needs no reset: outputs are gated by the count
        always_ff @(posedge clk) begin
            if (push) begin
                dat_q[wp_q] <= bus.i_data;
                idx_q[wp_q] <= bus.i_rdidx;
            end
        end

        assign bus.wbck_o_valid[k] = fifo_vld[k] || byp[k];
        assign bus.wbck_o_data[k*XLEN +: XLEN] =
            fifo_vld[k] ? dat_q[rp_q] : byp[k] ? bus.i_data : '0;
        assign bus.wbck_o_rdidx[k*RFIDX_W +: RFIDX_W] =
            fifo_vld[k] ? idx_q[rp_q] : byp[k] ? bus.i_rdidx : '0;
    end
endmodule

// File: tb/tb_qpu_exu_wbck_router.sv
// tb_qpu_exu_wbck_router: directed table, corner sequences and random traffic vs a queue model.
module tb_qpu_exu_wbck_router;
    localparam int XLEN = 32, NCH = 4, DEPTH = 2, RFIDX_W = 6, PC_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic o_err;
    always #5 clk = ~clk;

    qpu_exu_wbck_router_if #(.XLEN(XLEN), .NCH(NCH), .RFIDX_W(RFIDX_W), .PC_W(PC_W)) bus ();

    qpu_exu_wbck_router #(.XLEN(XLEN), .NCH(NCH), .DEPTH(DEPTH), .RFIDX_W(RFIDX_W), .PC_W(PC_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .o_err(o_err)
    );

    typedef struct packed {
        logic v; logic [3:0] ch; logic [31:0] d; logic [5:0] idx; logic [31:0] pc;
        logic [2:0] b; logic crdy; logic [3:0] wrdy;
        logic e_rdy; logic e_cv; logic [3:0] e_wv; logic e_err;
    } vec_t;

    vec_t tbl [19];
    int n_vec = 0, n_err = 0;

    logic                      m_cv, m_err;
    logic [PC_W-1:0]           m_pc;
    logic [2:0]                m_b;
    logic [XLEN+RFIDX_W-1:0]   mq [NCH][$];

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    function automatic logic m_ready();
        int n = $countones(bus.i_chsel);
        if (m_cv && !bus.cmt_o_ready) return 1'b0;
        if (n != 1) return 1'b1;
        for (int k = 0; k < NCH; k++)
            if (bus.i_chsel[k])
                return mq[k].size() < DEPTH || (mq[k].size() > 0 && bus.wbck_o_ready[k]);
        return 1'b0;
    endfunction

    task automatic m_reset();
        m_cv = 1'b0; m_err = 1'b0; m_pc = '0; m_b = '0;
        for (int k = 0; k < NCH; k++) mq[k].delete();
    endtask

    task automatic model_check();
        logic [NCH-1:0] ev = '0;
        logic [NCH*XLEN-1:0] ed = '0;
        logic [NCH*RFIDX_W-1:0] ei = '0;
        for (int k = 0; k < NCH; k++)
            if (mq[k].size() > 0) begin
                ev[k] = 1'b1;
                ed[k*XLEN +: XLEN] = mq[k][0][XLEN+RFIDX_W-1:RFIDX_W];
                ei[k*RFIDX_W +: RFIDX_W] = mq[k][0][RFIDX_W-1:0];
            end
        chk("i_ready", 128'(bus.i_ready), 128'(m_ready()));
        chk("cmt_valid", 128'(bus.cmt_o_valid), 128'(m_cv));
        chk("cmt_pc", 128'(bus.cmt_o_pc), 128'(m_cv ? m_pc : '0));
        chk("cmt_bjp", 128'({bus.cmt_o_bjp, bus.cmt_o_bjp_prdt, bus.cmt_o_bjp_rslv}),
            128'(m_cv && m_b[2] ? m_b : 3'b000));
        chk("wbck_valid", 128'(bus.wbck_o_valid), 128'(ev));
        chk("wbck_data", 128'(bus.wbck_o_data), 128'(ed));
        chk("wbck_rdidx", 128'(bus.wbck_o_rdidx), 128'(ei));
        chk("o_err", 128'(o_err), 128'(m_err));
    endtask

    task automatic apply(input logic v, input logic [NCH-1:0] ch, input logic [XLEN-1:0] d,
                         input logic [RFIDX_W-1:0] idx, input logic [PC_W-1:0] pc,
                         input logic [2:0] b, input logic crdy, input logic [NCH-1:0] wrdy);
        @(negedge clk);
        bus.i_valid = v; bus.i_chsel = ch; bus.i_data = d; bus.i_rdidx = idx; bus.i_pc = pc;
        {bus.i_bjp, bus.i_bjp_prdt, bus.i_bjp_rslv} = b;
        bus.cmt_o_ready = crdy; bus.wbck_o_ready = wrdy;
        #1 model_check();
    endtask

    task automatic model_edge();
        logic acc = bus.i_valid && m_ready();
        int n = $countones(bus.i_chsel);
        for (int k = 0; k < NCH; k++)
            if (mq[k].size() > 0 && bus.wbck_o_ready[k]) void'(mq[k].pop_front());
        if (acc) begin
            m_cv = 1'b1; m_pc = bus.i_pc;
            m_b = {bus.i_bjp, bus.i_bjp_prdt, bus.i_bjp_rslv};
            if (n == 1) begin
                for (int k = 0; k < NCH; k++)
                    if (bus.i_chsel[k]) mq[k].push_back({bus.i_data, bus.i_rdidx});
            end else if (n > 1) m_err = 1'b1;
        end else if (bus.cmt_o_ready) m_cv = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        tbl[0]  = '{1, 4'b0001, 32'h1234, 6'd5, 32'h100, 3'b000, 1, 4'hf, 1, 0, 4'h0, 0};
        tbl[1]  = '{0, 4'b0000, 32'h0,    6'd0, 32'h0,   3'b000, 1, 4'hb, 1, 1, 4'h1, 0};
        tbl[2]  = '{1, 4'b0100, 32'ha,    6'd1, 32'h104, 3'b000, 1, 4'hb, 1, 0, 4'h0, 0};
        tbl[3]  = '{1, 4'b0100, 32'hb,    6'd2, 32'h108, 3'b000, 1, 4'hb, 1, 1, 4'h4, 0};
        tbl[4]  = '{1, 4'b0100, 32'hc,    6'd3, 32'h10c, 3'b000, 1, 4'hb, 0, 1, 4'h4, 0};
        tbl[5]  = '{1, 4'b0001, 32'hd,    6'd4, 32'h110, 3'b000, 1, 4'hb, 1, 0, 4'h4, 0};
        tbl[6]  = '{0, 4'b0000, 32'h0,    6'd0, 32'h0,   3'b000, 1, 4'hf, 1, 1, 4'h5, 0};
        tbl[7]  = '{0, 4'b0000, 32'h0,    6'd0, 32'h0,   3'b000, 1, 4'hf, 1, 0, 4'h4, 0};
        tbl[8]  = '{0, 4'b0000, 32'h0,    6'd0, 32'h0,   3'b000, 1, 4'hf, 1, 0, 4'h0, 0};
        tbl[9]  = '{1, 4'b0000, 32'h0,    6'd0, 32'h200, 3'b011, 1, 4'hf, 1, 0, 4'h0, 0};
        tbl[10] = '{1, 4'b0000, 32'h0,    6'd0, 32'h204, 3'b111, 0, 4'hf, 0, 1, 4'h0, 0};
        tbl[11] = '{1, 4'b0000, 32'h0,    6'd0, 32'h204, 3'b111, 0, 4'hf, 0, 1, 4'h0, 0};
        tbl[12] = '{1, 4'b0000, 32'h0,    6'd0, 32'h204, 3'b111, 0, 4'hf, 0, 1, 4'h0, 0};
        tbl[13] = '{1, 4'b0000, 32'h0,    6'd0, 32'h204, 3'b111, 1, 4'hf, 1, 1, 4'h0, 0};
        tbl[14] = '{0, 4'b0000, 32'h0,    6'd0, 32'h0,   3'b000, 1, 4'hf, 1, 1, 4'h0, 0};
        tbl[15] = '{0, 4'b0000, 32'h0,    6'd0, 32'h0,   3'b000, 1, 4'hf, 1, 0, 4'h0, 0};
        tbl[16] = '{1, 4'b0110, 32'h77,   6'd7, 32'h300, 3'b000, 1, 4'hf, 1, 0, 4'h0, 0};
        tbl[17] = '{0, 4'b0000, 32'h0,    6'd0, 32'h0,   3'b000, 1, 4'hf, 1, 1, 4'h0, 1};
        tbl[18] = '{0, 4'b0000, 32'h0,    6'd0, 32'h0,   3'b000, 1, 4'hf, 1, 0, 4'h0, 1};

        bus.i_valid = 0; bus.i_chsel = '0; bus.i_data = '0; bus.i_rdidx = '0; bus.i_pc = '0;
        bus.i_bjp = 0; bus.i_bjp_prdt = 0; bus.i_bjp_rslv = 0;
        bus.cmt_o_ready = 1; bus.wbck_o_ready = '1;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmt_valid", 128'(bus.cmt_o_valid), 128'(0));
        chk("rst_wbck_valid", 128'(bus.wbck_o_valid), 128'(0));
        chk("rst_err", 128'(o_err), 128'(0));
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            apply(tbl[i].v, tbl[i].ch, tbl[i].d, tbl[i].idx, tbl[i].pc, tbl[i].b, tbl[i].crdy, tbl[i].wrdy);
            chk($sformatf("tbl%0d_ready", i), 128'(bus.i_ready), 128'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_cmt", i), 128'(bus.cmt_o_valid), 128'(tbl[i].e_cv));
            chk($sformatf("tbl%0d_wv", i), 128'(bus.wbck_o_valid), 128'(tbl[i].e_wv));
            chk($sformatf("tbl%0d_err", i), 128'(o_err), 128'(tbl[i].e_err));
            if (i == 1) chk("first_data", 128'(bus.wbck_o_data[XLEN-1:0]), 128'(32'h1234));
            if (i == 1) chk("first_rdidx", 128'(bus.wbck_o_rdidx[RFIDX_W-1:0]), 128'(6'd5));
            model_edge();
        end

        // channel 1 full with simultaneous pop and push, across pointer wrap
        apply(1, 4'b0010, 32'h11, 6'd1, 32'h400, 3'b000, 1, 4'b1101); model_edge();
        apply(1, 4'b0010, 32'h22, 6'd2, 32'h404, 3'b000, 1, 4'b1101); model_edge();
        apply(1, 4'b0010, 32'h33, 6'd3, 32'h408, 3'b000, 1, 4'b1101);
        chk("full_ready", 128'(bus.i_ready), 128'(0));
        chk("full_head", 128'(bus.wbck_o_data[XLEN +: XLEN]), 128'(32'h11));
        model_edge();
        apply(1, 4'b0010, 32'h33, 6'd3, 32'h408, 3'b000, 1, 4'b1111);
        chk("pushpop_ready", 128'(bus.i_ready), 128'(1));
        chk("pushpop_head", 128'(bus.wbck_o_data[XLEN +: XLEN]), 128'(32'h11));
        model_edge();
        apply(1, 4'b0010, 32'h44, 6'd4, 32'h40c, 3'b000, 1, 4'b1111);
        chk("wrap_head", 128'(bus.wbck_o_data[XLEN +: XLEN]), 128'(32'h22));
        model_edge();
        apply(0, 4'b0010, 32'h0, 6'd0, 32'h0, 3'b000, 1, 4'b1101);
        chk("still_full", 128'(bus.i_ready), 128'(0));
        chk("wrap_head2", 128'(bus.wbck_o_data[XLEN +: XLEN]), 128'(32'h33));
        model_edge();
        apply(0, 4'b0000, 32'h0, 6'd0, 32'h0, 3'b000, 1, 4'b1111); model_edge();
        apply(0, 4'b0000, 32'h0, 6'd0, 32'h0, 3'b000, 1, 4'b1111);
        chk("wrap_head3", 128'(bus.wbck_o_data[XLEN +: XLEN]), 128'(32'h44));
        model_edge();

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            int r = $urandom_range(0, 9);
            logic [NCH-1:0] ch = r < 4 ? NCH'(1 << r) : r == 8 ? NCH'($urandom) : '0;
            apply(1'($urandom), ch, $urandom, RFIDX_W'($urandom), $urandom, 3'($urandom),
                  $urandom_range(0, 3) != 0, NCH'($urandom));
            model_edge();
        end

        // async reset with entries queued and commit slot full
        apply(1, 4'b1000, 32'haa, 6'd10, 32'h500, 3'b000, 1, 4'b0111); model_edge();
        apply(1, 4'b1000, 32'hbb, 6'd11, 32'h504, 3'b000, 1, 4'b0111); model_edge();
        apply(0, 4'b0000, 32'h0, 6'd0, 32'h0, 3'b000, 0, 4'b0000);
        chk("pre_rst_cmt", 128'(bus.cmt_o_valid), 128'(1));
        chk("pre_rst_wv3", 128'(bus.wbck_o_valid[3]), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cmt", 128'(bus.cmt_o_valid), 128'(0));
        chk("arst_wv", 128'(bus.wbck_o_valid), 128'(0));
        chk("arst_data", 128'(bus.wbck_o_data), 128'(0));
        chk("arst_pc", 128'(bus.cmt_o_pc), 128'(0));
        chk("arst_err", 128'(o_err), 128'(0));
        m_reset();
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            apply(0, 4'b0000, 32'h0, 6'd0, 32'h0, 3'b000, 1, 4'b1111);
            model_edge();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
